// File: rtl/matrix_loader.sv
// Byte-serial operand loader: streams 16 A and 9 B bytes into shadow registers
// and commits them atomically to the parallel operand outputs.
module matrix_loader #(
    parameter int DATA_W = 8,
    parameter int A_N    = 16,
    parameter int B_N    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [A_N*DATA_W-1:0]   a_flat_o,
    output logic [B_N*DATA_W-1:0]   b_flat_o,
    output logic [4:0]              index_o,
    output logic                    busy_o,
    output logic                    done_capture
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    localparam logic [4:0] LAST_A = 5'(A_N - 1);
    localparam logic [4:0] LAST   = 5'(A_N + B_N - 1);

    state_t            state, state_next;
    logic              accept;
    logic [DATA_W-1:0] shadow_a [A_N];
    // The last B byte never needs a shadow slot: it is merged directly at commit.
    logic [DATA_W-1:0] shadow_b [B_N-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        ready_o      = 1'b0;
        busy_o       = 1'b0;
        done_capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) state_next = LOAD_A;
            end
            LOAD_A: begin
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (abort_i)                          state_next = IDLE;
                else if (valid_i && index_o == LAST_A) state_next = LOAD_B;
            end
            LOAD_B: begin
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (abort_i)                        state_next = IDLE;
                else if (valid_i && index_o == LAST) state_next = DONE;
            end
            DONE: begin
                busy_o       = 1'b1;
                done_capture = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = valid_i && ready_o && !abort_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_o  <= '0;
            a_flat_o <= '0;
            b_flat_o <= '0;
            for (int i = 0; i < A_N; i++)     shadow_a[i] <= '0;
            for (int i = 0; i < B_N - 1; i++) shadow_b[i] <= '0;
        end else if (state == IDLE) begin
            if (start_i) index_o <= '0;
        end else if ((state == LOAD_A || state == LOAD_B) && abort_i) begin
            index_o <= '0;
            for (int i = 0; i < A_N; i++)     shadow_a[i] <= '0;
            for (int i = 0; i < B_N - 1; i++) shadow_b[i] <= '0;
        end else if (accept) begin
            index_o <= index_o + 5'd1;
            if (state == LOAD_A) begin
                shadow_a[index_o[3:0]] <= data_i;
            end else if (index_o == LAST) begin
                for (int i = 0; i < A_N; i++)
                    a_flat_o[i*DATA_W +: DATA_W] <= shadow_a[i];
                for (int i = 0; i < B_N - 1; i++)
                    b_flat_o[i*DATA_W +: DATA_W] <= shadow_b[i];
                b_flat_o[(B_N-1)*DATA_W +: DATA_W] <= data_i;
            end else begin
                shadow_b[index_o[2:0]] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader: reset, full, throttled,
// aborted, reset-interrupted and ignored-input loads.
module tb_matrix_loader;

    logic         clk;
    logic         reset;
    logic         start_i;
    logic         abort_i;
    logic [7:0]   data_i;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] a_flat_o;
    logic [71:0]  b_flat_o;
    logic [4:0]   index_o;
    logic         busy_o;
    logic         done_capture;

    int tests_run;
    int tests_failed;
    int done_count;
    int done_at;
    int n_acc;
    logic v;

    matrix_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .a_flat_o     (a_flat_o),
        .b_flat_o     (b_flat_o),
        .index_o      (index_o),
        .busy_o       (busy_o),
        .done_capture (done_capture)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] exp_a(input logic [7:0] base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    function automatic logic [127:0] exp_b(input logic [7:0] base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    // Inputs change 1 time unit after the rising edge, so sampling there sees settled registers.
    task automatic applyStimulus(input logic s, input logic ab, input logic vl, input logic [7:0] d);
        start_i = s;
        abort_i = ab;
        valid_i = vl;
        data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        checkOutput("rst_ready", 128'(ready_o), 128'(0));
        checkOutput("rst_busy",  128'(busy_o), 128'(0));
        checkOutput("rst_done",  128'(done_capture), 128'(0));
        checkOutput("rst_index", 128'(index_o), 128'(0));
        checkOutput("rst_a",     a_flat_o, 128'(0));
        checkOutput("rst_b",     128'(b_flat_o), 128'(0));

        reset = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("idle_ready", 128'(ready_o), 128'(0));
        checkOutput("idle_busy",  128'(busy_o), 128'(0));
        checkOutput("idle_a",     a_flat_o, 128'(0));

        // Full back-to-back load of 1..25
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("full_ready_start", 128'(ready_o), 128'(1));
        checkOutput("full_index_start", 128'(index_o), 128'(0));
        done_count = 0;
        for (int k = 1; k <= 25; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(k));
            if (done_capture) done_count++;
            if (k == 24) begin
                checkOutput("full_hold_a", a_flat_o, 128'(0));
                checkOutput("full_index24", 128'(index_o), 128'(24));
            end
        end
        checkOutput("full_done_e25", 128'(done_capture), 128'(1));
        checkOutput("full_ready_done", 128'(ready_o), 128'(0));
        checkOutput("full_index25", 128'(index_o), 128'(25));
        checkOutput("full_a", a_flat_o, exp_a(8'd1));
        checkOutput("full_b", 128'(b_flat_o), exp_b(8'd17));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            if (done_capture) done_count++;
        end
        checkOutput("full_done_once", 128'(done_count), 128'(1));
        checkOutput("full_busy_after", 128'(busy_o), 128'(0));
        checkOutput("full_index_hold", 128'(index_o), 128'(25));

        // Throttled load: valid on every other cycle, bytes A0..B8
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        done_at = 0;
        n_acc   = 0;
        for (int i = 1; i <= 50; i++) begin
            v = (i % 2 == 0);
            applyStimulus(1'b0, 1'b0, v, 8'hA0 + 8'(n_acc));
            if (v) n_acc++;
            if (done_capture && done_at == 0) done_at = i;
            if (i == 48) checkOutput("thr_hold_a", a_flat_o, exp_a(8'd1));
        end
        checkOutput("thr_done_at", 128'(done_at), 128'(50));
        checkOutput("thr_a", a_flat_o, exp_a(8'hA0));
        checkOutput("thr_b", 128'(b_flat_o), exp_b(8'hB0));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Reload 1..25, then abort a second load partway
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 25; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(k));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reload_a", a_flat_o, exp_a(8'd1));
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        checkOutput("abort_pre_index", 128'(index_o), 128'(10));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
        checkOutput("abort_index", 128'(index_o), 128'(0));
        checkOutput("abort_ready", 128'(ready_o), 128'(0));
        checkOutput("abort_done", 128'(done_capture), 128'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_done_next", 128'(done_capture), 128'(0));
        checkOutput("abort_a", a_flat_o, exp_a(8'd1));
        checkOutput("abort_b", 128'(b_flat_o), exp_b(8'd17));

        // Valid bursts in IDLE are not accepted
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h55);
        checkOutput("idle_valid_index", 128'(index_o), 128'(0));
        checkOutput("idle_valid_busy", 128'(busy_o), 128'(0));

        // Start pulses during LOAD_B are ignored; start in DONE is not held over
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 25; k++) applyStimulus(k >= 16, 1'b0, 1'b1, 8'h40 + 8'(k));
        checkOutput("ign_done", 128'(done_capture), 128'(1));
        checkOutput("ign_a", a_flat_o, exp_a(8'h40));
        checkOutput("ign_b", 128'(b_flat_o), exp_b(8'h50));
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("done_start_busy", 128'(busy_o), 128'(0));
        checkOutput("done_start_index", 128'(index_o), 128'(25));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("done_start_ready", 128'(ready_o), 128'(0));

        // Asynchronous reset between edges after 20 bytes
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
        checkOutput("arst_pre_index", 128'(index_o), 128'(20));
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_a", a_flat_o, 128'(0));
        checkOutput("arst_b", 128'(b_flat_o), 128'(0));
        checkOutput("arst_index", 128'(index_o), 128'(0));
        checkOutput("arst_ready", 128'(ready_o), 128'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h11);
        checkOutput("arst_idle_busy", 128'(busy_o), 128'(0));
        checkOutput("arst_idle_index", 128'(index_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
